// File: rtl/entry_pkg.sv
// Shared definitions for the user-entry controller.
//   state_t   : controller FSM states
//   LED_W     : number of display LEDs
//   ERROR_LED : fixed LED pattern shown while the core has timed out
package entry_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ENTRY,
    ISSUE,
    WAIT,
    SHOW,
    ERROR
  } state_t;

  localparam int LED_W = 6;

  localparam logic [LED_W-1:0] ERROR_LED = 6'b101010;

endpackage

// File: rtl/button_sync.sv
// Two-flop synchroniser followed by a rising-edge detector for one raw
// pushbutton.
//   clock   : system clock
//   reset   : asynchronous, active-low reset
//   btn_raw : raw button level, asynchronous to clock
//   pulse   : one-cycle high pulse per synchronised rising edge
// A raw rise is visible on pulse after the second clock edge, so logic that
// consumes pulse reacts on the third edge. No debounce is applied.
module button_sync (
  input  logic clock,
  input  logic reset,
  input  logic btn_raw,
  output logic pulse
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;

  always_comb begin
    meta_d = btn_raw;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign pulse = sync_q & ~prev_q;

endmodule

// File: rtl/entry_controller.sv
// Sequences the user-entry datapath between the chip pins and an algorithm
// core: synchronises five pushbuttons, shifts entered bits into an operand
// buffer, runs a start/done handshake with the selected core and drives the
// LEDs.
//   clock    : system clock, all flops on posedge
//   reset    : asynchronous, active-low reset
//   confirm, clear, algo_btn, enter0, enter1 : raw buttons
//   start    : one-cycle pulse to the core
//   operand  : entered value, held from start until done
//   algo_sel : selected algorithm, 0..NUM_ALGO-1
//   done     : one-cycle completion pulse from the core
//   result   : core output, valid while done is high
//   busy     : high while a request is outstanding (ISSUE/WAIT)
//   led      : display
module entry_controller
  import entry_pkg::*;
#(
  parameter int WIDTH    = 6,
  parameter int NUM_ALGO = 2,
  parameter int TIMEOUT  = 1024
) (
  input  logic                                             clock,
  input  logic                                             reset,
  input  logic                                             confirm,
  input  logic                                             clear,
  input  logic                                             algo_btn,
  input  logic                                             enter0,
  input  logic                                             enter1,
  output logic                                             start,
  output logic [WIDTH-1:0]                                 operand,
  output logic [((NUM_ALGO > 1) ? $clog2(NUM_ALGO) : 1)-1:0] algo_sel,
  input  logic                                             done,
  input  logic [WIDTH-1:0]                                 result,
  output logic                                             busy,
  output logic [LED_W-1:0]                                 led
);

  localparam int ALGO_W = (NUM_ALGO > 1) ? $clog2(NUM_ALGO) : 1;
  localparam int CNT_W  = $clog2(WIDTH + 1);
  localparam int TMR_W  = $clog2(TIMEOUT + 1);

  logic clear_p, confirm_p, algo_p, enter0_p, enter1_p;

  button_sync u_sync_clear   (.clock(clock), .reset(reset), .btn_raw(clear),    .pulse(clear_p));
  button_sync u_sync_confirm (.clock(clock), .reset(reset), .btn_raw(confirm),  .pulse(confirm_p));
  button_sync u_sync_algo    (.clock(clock), .reset(reset), .btn_raw(algo_btn), .pulse(algo_p));
  button_sync u_sync_enter0  (.clock(clock), .reset(reset), .btn_raw(enter0),   .pulse(enter0_p));
  button_sync u_sync_enter1  (.clock(clock), .reset(reset), .btn_raw(enter1),   .pulse(enter1_p));

  state_t               state_q,   state_d;
  logic [WIDTH-1:0]     buffer_q,  buffer_d;
  logic [CNT_W-1:0]     count_q,   count_d;
  logic [TMR_W-1:0]     timer_q,   timer_d;
  logic [ALGO_W-1:0]    algo_q,    algo_d;
  logic [WIDTH-1:0]     result_q,  result_d;
  logic                 start_q,   start_d;
  logic                 busy_q,    busy_d;
  logic [WIDTH-1:0]     operand_q, operand_d;
  logic [LED_W-1:0]     led_q,     led_d;

  // Only the highest-priority pulse of a cycle survives; a simultaneous
  // enter0+enter1 cancels out.
  logic ev_clear, ev_confirm, ev_algo, ev_enter, enter_bit;
  logic [ALGO_W-1:0] algo_next;

  always_comb begin
    ev_clear   = clear_p;
    ev_confirm = confirm_p & ~clear_p;
    ev_algo    = algo_p & ~confirm_p & ~clear_p;
    ev_enter   = (enter0_p ^ enter1_p) & ~algo_p & ~confirm_p & ~clear_p;
    enter_bit  = enter1_p;
    algo_next  = (algo_q == ALGO_W'(NUM_ALGO - 1)) ? '0 : algo_q + ALGO_W'(1);
  end

  function automatic logic [LED_W-1:0] to_led(input logic [WIDTH-1:0] v);
    logic [LED_W+WIDTH-1:0] ext;
    ext = {{LED_W{1'b0}}, v};
    return ext[LED_W-1:0];
  endfunction

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      buffer_q  <= '0;
      count_q   <= '0;
      timer_q   <= '0;
      algo_q    <= '0;
      result_q  <= '0;
      start_q   <= 1'b0;
      busy_q    <= 1'b0;
      operand_q <= '0;
      led_q     <= '0;
    end else begin
      state_q   <= state_d;
      buffer_q  <= buffer_d;
      count_q   <= count_d;
      timer_q   <= timer_d;
      algo_q    <= algo_d;
      result_q  <= result_d;
      start_q   <= start_d;
      busy_q    <= busy_d;
      operand_q <= operand_d;
      led_q     <= led_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    buffer_d = buffer_q;
    count_d  = count_q;
    timer_d  = timer_q;
    algo_d   = algo_q;
    result_d = result_q;

    unique case (state_q)
      IDLE, SHOW: begin
        if (ev_clear) begin
          state_d  = IDLE;
          buffer_d = '0;
          count_d  = '0;
        end else if (ev_algo) begin
          algo_d = algo_next;
        end else if (ev_enter) begin
          state_d  = ENTRY;
          buffer_d = WIDTH'(enter_bit);
          count_d  = CNT_W'(1);
        end
      end
      ENTRY: begin
        if (ev_clear) begin
          state_d  = IDLE;
          buffer_d = '0;
          count_d  = '0;
        end else if (ev_confirm) begin
          if (count_q == CNT_W'(WIDTH)) state_d = ISSUE;
        end else if (ev_algo) begin
          algo_d = algo_next;
        end else if (ev_enter && (count_q < CNT_W'(WIDTH))) begin
          buffer_d = (buffer_q << 1) | WIDTH'(enter_bit);
          count_d  = count_q + CNT_W'(1);
        end
      end
      ISSUE: begin
        state_d = WAIT;
        timer_d = '0;
      end
      WAIT: begin
        // done wins over a timeout expiring in the same cycle
        if (done) begin
          state_d  = SHOW;
          result_d = result;
        end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
          state_d = ERROR;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      ERROR: begin
        if (ev_clear) begin
          state_d  = IDLE;
          buffer_d = '0;
          count_d  = '0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so the registered copies line
  // up with the state register.
  always_comb begin
    start_d   = (state_d == ISSUE);
    busy_d    = (state_d == ISSUE) || (state_d == WAIT);
    operand_d = (state_d == ISSUE) ? buffer_d : operand_q;
    unique case (state_d)
      IDLE:                led_d = '0;
      ENTRY, ISSUE, WAIT:  led_d = to_led(buffer_d);
      SHOW:                led_d = to_led(result_d);
      ERROR:               led_d = ERROR_LED;
      default:             led_d = '0;
    endcase
  end

  assign start    = start_q;
  assign busy     = busy_q;
  assign operand  = operand_q;
  assign algo_sel = algo_q;
  assign led      = led_q;

endmodule

// File: tb/tb_entry_controller.sv
// Self-checking bench for entry_controller: directed scenarios followed by
// random button/done traffic, compared every clock against an event-level
// reference model of the controller.
module tb_entry_controller;

  localparam int W  = 6;
  localparam int NA = 2;
  localparam int TO = 1024;

  localparam int S_IDLE  = 0;
  localparam int S_ENTRY = 1;
  localparam int S_ISSUE = 2;
  localparam int S_WAIT  = 3;
  localparam int S_SHOW  = 4;
  localparam int S_ERROR = 5;

  // button mask bit order
  localparam logic [4:0] B_CLEAR   = 5'b00001;
  localparam logic [4:0] B_CONFIRM = 5'b00010;
  localparam logic [4:0] B_ALGO    = 5'b00100;
  localparam logic [4:0] B_ENTER0  = 5'b01000;
  localparam logic [4:0] B_ENTER1  = 5'b10000;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic [4:0]   btn   = '0;
  logic         done  = 1'b0;
  logic [W-1:0] result = '0;
  logic         start, busy;
  logic [W-1:0] operand;
  logic [0:0]   algo_sel;
  logic [5:0]   led;

  int tests = 0;
  int fails = 0;

  int m_state, m_buf, m_cnt, m_algo, m_res, m_wait;

  entry_controller #(.WIDTH(W), .NUM_ALGO(NA), .TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset),
    .confirm(btn[1]), .clear(btn[0]), .algo_btn(btn[2]),
    .enter0(btn[3]), .enter1(btn[4]),
    .start(start), .operand(operand), .algo_sel(algo_sel),
    .done(done), .result(result), .busy(busy), .led(led)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_state = S_IDLE; m_buf = 0; m_cnt = 0; m_algo = 0; m_res = 0; m_wait = 0;
  endfunction

  // One clock edge of the controller as described by its rules.
  function automatic void model_step(input logic [4:0] ev, input logic dn, input logic [W-1:0] res);
    int b;
    if (m_state == S_ISSUE) begin
      m_state = S_WAIT;
      m_wait  = 0;
    end else if (m_state == S_WAIT) begin
      if (dn) begin
        m_res   = int'(res);
        m_state = S_SHOW;
      end else begin
        m_wait++;
        if (m_wait == TO) m_state = S_ERROR;
      end
    end else if (ev[0]) begin
      m_state = S_IDLE; m_buf = 0; m_cnt = 0;
    end else if (ev[1]) begin
      if (m_state == S_ENTRY && m_cnt == W) m_state = S_ISSUE;
    end else if (ev[2]) begin
      if (m_state != S_ERROR) m_algo = (m_algo + 1) % NA;
    end else if (ev[3] != ev[4]) begin
      b = ev[4] ? 1 : 0;
      if (m_state == S_IDLE || m_state == S_SHOW) begin
        m_state = S_ENTRY; m_buf = b; m_cnt = 1;
      end else if (m_state == S_ENTRY && m_cnt < W) begin
        m_buf = (m_buf * 2 + b) % (1 << W);
        m_cnt++;
      end
    end
  endfunction

  function automatic int exp_led();
    case (m_state)
      S_ENTRY: return m_buf;
      S_SHOW:  return m_res;
      S_ERROR: return 'h2A;
      default: return 0;
    endcase
  endfunction

  task automatic check_all();
    checkOutput("start", 32'(start), 32'(m_state == S_ISSUE));
    checkOutput("busy", 32'(busy), 32'(m_state == S_ISSUE || m_state == S_WAIT));
    checkOutput("algo_sel", 32'(algo_sel), 32'(m_algo));
    if (m_state == S_ISSUE || m_state == S_WAIT)
      checkOutput("operand", 32'(operand), 32'(m_buf));
    else
      checkOutput("led", 32'(led), 32'(exp_led()));
  endtask

  task automatic tick(input logic [4:0] ev, input logic dn, input logic [W-1:0] res);
    @(posedge clock);
    model_step(ev, dn, res);
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick('0, 1'b0, '0);
  endtask

  // Raw press held three edges (effect lands on the third), then released
  // long enough for the edge detector to re-arm.
  task automatic applyStimulus(input logic [4:0] mask);
    btn = mask;
    tick('0, 1'b0, '0);
    tick('0, 1'b0, '0);
    tick(mask, 1'b0, '0);
    btn = '0;
    idle(3);
  endtask

  task automatic applyDone(input logic [W-1:0] res);
    done   = 1'b1;
    result = res;
    tick('0, 1'b1, res);
    done   = 1'b0;
    result = W'($urandom);
  endtask

  task automatic enter_bits(input logic [W:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) applyStimulus(bits[i] ? B_ENTER1 : B_ENTER0);
  endtask

  task automatic doReset();
    reset = 1'b0;
    btn   = '0;
    done  = 1'b0;
    #1;
    checkOutput("rst_start", 32'(start), 0);
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_led", 32'(led), 0);
    checkOutput("rst_algo", 32'(algo_sel), 0);
    checkOutput("rst_operand", 32'(operand), 0);
    @(posedge clock);
    #1;
    checkOutput("rst_hold_led", 32'(led), 0);
    checkOutput("rst_hold_busy", 32'(busy), 0);
    @(negedge clock);
    reset = 1'b1;
    model_reset();
  endtask

  initial begin
    logic [4:0] m;
    int r;
    model_reset();
    #3;
    doReset();

    // full entry, issue and completion
    enter_bits(7'b0101101, 6);
    checkOutput("entry_led", 32'(led), 32'h2D);
    applyStimulus(B_CONFIRM);
    checkOutput("operand_101101", 32'(operand), 32'h2D);
    applyDone(6'h2A);
    checkOutput("show_led", 32'(led), 32'h2A);
    checkOutput("show_busy", 32'(busy), 0);

    // seven entries saturate, early confirm ignored
    applyStimulus(B_CLEAR);
    enter_bits(7'b1111110, 7);
    checkOutput("sat_led", 32'(led), 32'h3F);
    applyStimulus(B_CLEAR);
    enter_bits(7'b0010110, 5);
    applyStimulus(B_CONFIRM);
    checkOutput("early_confirm_busy", 32'(busy), 0);

    // clear beats confirm in the same cycle
    applyStimulus(B_CLEAR);
    enter_bits(7'b0110011, 6);
    applyStimulus(B_CLEAR | B_CONFIRM);
    checkOutput("clr_cfm_led", 32'(led), 0);

    // algorithm cycling, frozen during WAIT
    for (int i = 0; i < 3; i++) applyStimulus(B_ALGO);
    checkOutput("algo_x3", 32'(algo_sel), 1);
    enter_bits(7'b0000001, 6);
    applyStimulus(B_CONFIRM);
    applyStimulus(B_ALGO);
    applyStimulus(B_ALGO | B_CLEAR);
    checkOutput("algo_wait", 32'(algo_sel), 1);
    applyDone(6'h15);

    // timeout into ERROR, then clear; dual enter ignored
    enter_bits(7'b0111000, 6);
    applyStimulus(B_CONFIRM);
    idle(TO);
    checkOutput("err_led", 32'(led), 32'h2A);
    applyStimulus(B_ENTER1);
    applyStimulus(B_ALGO);
    applyStimulus(B_CLEAR);
    checkOutput("err_clr_led", 32'(led), 0);
    applyStimulus(B_ENTER0 | B_ENTER1);
    checkOutput("dual_idle_led", 32'(led), 0);
    enter_bits(7'b0000011, 2);
    applyStimulus(B_ENTER0 | B_ENTER1);
    checkOutput("dual_entry_led", 32'(led), 32'h3);

    // reset while waiting on the core, then a stale done
    enter_bits(7'b0000011, 4);
    applyStimulus(B_CONFIRM);
    #3;
    doReset();
    applyDone(6'h3C);
    checkOutput("stale_done_led", 32'(led), 0);

    // random traffic
    for (int k = 0; k < 300; k++) begin
      r = int'($urandom_range(0, 99));
      if (m_state == S_WAIT) begin
        if (r < 70) begin
          idle(int'($urandom_range(0, 4)));
          if (m_state == S_WAIT) applyDone(W'($urandom));
        end else begin
          applyStimulus(5'($urandom_range(1, 31)));
        end
      end else begin
        if (r < 55)      m = ($urandom_range(0, 1) != 0) ? B_ENTER1 : B_ENTER0;
        else if (r < 70) m = B_CONFIRM;
        else if (r < 78) m = B_ALGO;
        else if (r < 83) m = B_CLEAR;
        else             m = 5'($urandom_range(1, 31));
        if (r >= 95) applyDone(W'($urandom));
        else         applyStimulus(m);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
